// File: rtl/key_switch_reader_pkg.sv
// Shared constants and register-map decode for the key/switch reader.
package key_switch_reader_pkg;

  localparam int unsigned KSR_DEBOUNCE_CYCLES = 25000;
  localparam int unsigned KSR_SW_W            = 32;
  localparam int unsigned KSR_KEY_W           = 8;

  localparam logic [31:0] KSR_SW_ADDR  = 32'h0000_7F60;
  localparam logic [31:0] KSR_KEY_ADDR = 32'h0000_7F64;
  localparam logic [31:0] KSR_EVT_ADDR = 32'h0000_7F68;

  typedef enum logic [1:0] {
    KSR_SEL_NONE,
    KSR_SEL_SW,
    KSR_SEL_KEY,
    KSR_SEL_EVT
  } ksr_sel_e;

  // Word-granular decode; callers pass addr[31:2] so byte offsets never matter.
  function automatic ksr_sel_e ksr_decode(input logic [29:0] word_addr);
    ksr_sel_e sel;
    sel = KSR_SEL_NONE;
    if (word_addr == KSR_SW_ADDR[31:2]) begin
      sel = KSR_SEL_SW;
    end else if (word_addr == KSR_KEY_ADDR[31:2]) begin
      sel = KSR_SEL_KEY;
    end else if (word_addr == KSR_EVT_ADDR[31:2]) begin
      sel = KSR_SEL_EVT;
    end
    return sel;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Active-low raw bus -> 2-flop synchronizer -> tick-sampled debounce.
// A bit only changes when two consecutive tick samples agree.
module input_debouncer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] raw_n_i,
  output logic [WIDTH-1:0] deb_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] sample_q;
  logic [WIDTH-1:0] sample_d;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] agree_c;

  always_comb begin
    agree_c  = ~(sample_q ^ sync2_q);
    sample_d = sample_q;
    deb_d    = deb_q;
    if (tick_i) begin
      sample_d = sync2_q;
      deb_d    = (sync2_q & agree_c) | (deb_q & ~agree_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sample_q <= '0;
      deb_q    <= '0;
    end else begin
      sync1_q  <= ~raw_n_i;
      sync2_q  <= sync1_q;
      sample_q <= sample_d;
      deb_q    <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/key_switch_reader.sv
// Memory-mapped DIP-switch / push-key reader with debounce, sticky
// key-press events cleared on read, and a level interrupt.
module key_switch_reader
  import key_switch_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KSR_DEBOUNCE_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic [31:0] dip_sw,
  input  logic [7:0]  key,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 tick_c;

  logic [KSR_SW_W-1:0]  sw_deb;
  logic [KSR_KEY_W-1:0] key_deb;
  logic [KSR_KEY_W-1:0] key_prev_q;
  logic [KSR_KEY_W-1:0] key_rise_c;

  logic [KSR_KEY_W-1:0] evt_q;
  logic [KSR_KEY_W-1:0] evt_d;
  logic                 evt_clr_c;
  logic                 irq_q;
  logic                 irq_d;

  ksr_sel_e             sel_c;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  // Shared debounce tick: high in the last cycle of each period.
  always_comb begin
    tick_c = (cnt_q == CNT_LAST);
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  input_debouncer #(
    .WIDTH (KSR_SW_W)
  ) u_sw_deb (
    .clk     (clk),
    .reset   (reset),
    .tick_i  (tick_c),
    .raw_n_i (dip_sw),
    .deb_o   (sw_deb)
  );

  input_debouncer #(
    .WIDTH (KSR_KEY_W)
  ) u_key_deb (
    .clk     (clk),
    .reset   (reset),
    .tick_i  (tick_c),
    .raw_n_i (key),
    .deb_o   (key_deb)
  );

  // Press detection and sticky events; a same-cycle new press beats the clear.
  always_comb begin
    sel_c      = ksr_decode(addr[31:2]);
    key_rise_c = key_deb & ~key_prev_q;
    evt_clr_c  = rd_en && (sel_c == KSR_SEL_EVT);
    evt_d      = (evt_clr_c ? '0 : evt_q) | key_rise_c;
    irq_d      = |evt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      key_prev_q <= '0;
      evt_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      key_prev_q <= key_deb;
      evt_q      <= evt_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  // Read mux depends on address only.
  always_comb begin
    rdata = '0;
    case (sel_c)
      KSR_SEL_SW:  rdata = sw_deb;
      KSR_SEL_KEY: rdata = {24'h0, key_deb};
      KSR_SEL_EVT: rdata = {24'h0, evt_q};
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_key_switch_reader.sv
// Directed bench for key_switch_reader with a short debounce period.
module tb_key_switch_reader;
  import key_switch_reader_pkg::*;

  localparam int unsigned DBC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        rd_en;
  logic [31:0] dip_sw;
  logic [7:0]  key;
  logic [31:0] rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_switch_reader #(
    .DEBOUNCE_CYCLES (DBC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .rd_en  (rd_en),
    .dip_sw (dip_sw),
    .key    (key),
    .rdata  (rdata),
    .irq    (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check_eq(tag, rdata, exp);
  endtask

  // Clearing read of the event register; rdata must show the pre-clear value.
  task automatic clr_read(input string tag, input logic [31:0] exp_before);
    addr  = KSR_EVT_ADDR;
    rd_en = 1'b1;
    #1;
    check_eq(tag, rdata, exp_before);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;

    reset  = 1'b1;
    addr   = '0;
    rd_en  = 1'b0;
    dip_sw = '1;
    key    = '1;
    cycles(3);
    check_eq("rst_irq", 32'(irq), 32'h0);
    rd_chk("rst_sw",  KSR_SW_ADDR,  32'h0);
    rd_chk("rst_key", KSR_KEY_ADDR, 32'h0);
    cycles(1);
    rd_chk("rst_evt", KSR_EVT_ADDR, 32'h0);
    reset = 1'b0;

    // Switches: low nibble pressed (active-low).
    dip_sw = 32'hFFFF_FFF0;
    cycles(20);
    rd_chk("sw_deb", KSR_SW_ADDR, 32'h0000_000F);
    rd_chk("sw_lsb_ignored", 32'h0000_7F63, 32'h0000_000F);
    check_eq("sw_irq", 32'(irq), 32'h0);
    cycles(1);
    addr  = 32'h0000_7F6C;
    rd_en = 1'b1;
    #1;
    check_eq("unmapped_7f6c", rdata, 32'h0);
    cycles(1);
    rd_en = 1'b0;
    rd_chk("sw_after_unmapped_rd", KSR_SW_ADDR, 32'h0000_000F);
    rd_chk("unmapped_7f5c", 32'h0000_7F5C, 32'h0);

    // Short glitch on key[2] must be rejected.
    key = 8'hFB;
    cycles(2);
    key = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      check_eq("glitch_irq", 32'(irq), 32'h0);
    end
    rd_chk("glitch_key", KSR_KEY_ADDR, 32'h0);
    rd_chk("glitch_evt", KSR_EVT_ADDR, 32'h0);

    // Held key[2] press, then clearing read.
    key = 8'hFB;
    cycles(20);
    rd_chk("k2_key", KSR_KEY_ADDR, 32'h04);
    rd_chk("k2_evt", KSR_EVT_ADDR, 32'h04);
    check_eq("k2_irq", 32'(irq), 32'h1);
    cycles(1);
    clr_read("k2_clr_rdata", 32'h04);
    rd_chk("k2_evt_cleared", KSR_EVT_ADDR, 32'h0);
    check_eq("k2_irq_cleared", 32'(irq), 32'h0);

    // Release raises no event; re-press sets bit 2 again.
    key = 8'hFF;
    cycles(20);
    rd_chk("k2_rel_key", KSR_KEY_ADDR, 32'h0);
    rd_chk("k2_rel_evt", KSR_EVT_ADDR, 32'h0);
    check_eq("k2_rel_irq", 32'(irq), 32'h0);
    key = 8'hFB;
    cycles(20);
    rd_chk("k2_repress_evt", KSR_EVT_ADDR, 32'h04);

    // key[5] press edge lands in the same cycle as a clearing read.
    key   = 8'hDB;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycles(1);
      addr = KSR_KEY_ADDR;
      #1;
      if (rdata[5]) found = 1'b1;
    end
    check_eq("k5_deb_seen", 32'(found), 32'h1);
    check_eq("k5_key", rdata, 32'h24);
    clr_read("k5_same_cyc_rdata", 32'h04);
    rd_chk("k5_set_wins", KSR_EVT_ADDR, 32'h20);
    check_eq("k5_irq", 32'(irq), 32'h1);
    clr_read("k5_clr_rdata", 32'h20);
    rd_chk("k5_evt_cleared", KSR_EVT_ADDR, 32'h0);

    // key[0] press then release.
    key = 8'hFF;
    cycles(20);
    rd_chk("all_rel_key", KSR_KEY_ADDR, 32'h0);
    rd_chk("all_rel_evt", KSR_EVT_ADDR, 32'h0);
    key = 8'hFE;
    cycles(20);
    rd_chk("k0_key", KSR_KEY_ADDR, 32'h01);
    rd_chk("k0_evt", KSR_EVT_ADDR, 32'h01);
    cycles(1);
    clr_read("k0_clr_rdata", 32'h01);
    key   = 8'hFF;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycles(1);
      addr = KSR_KEY_ADDR;
      #1;
      if (rdata == 32'h0) found = 1'b1;
    end
    check_eq("k0_rel_within_10", 32'(found), 32'h1);
    cycles(3);
    rd_chk("k0_rel_no_evt", KSR_EVT_ADDR, 32'h0);
    check_eq("k0_rel_irq", 32'(irq), 32'h0);

    // Reset in the middle of key[1] debounce.
    key = 8'hFD;
    cycles(5);
    reset = 1'b1;
    cycles(2);
    rd_chk("midrst_key", KSR_KEY_ADDR, 32'h0);
    rd_chk("midrst_evt", KSR_EVT_ADDR, 32'h0);
    check_eq("midrst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    rd_chk("midrst_sw", KSR_SW_ADDR, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycles(1);
      addr = KSR_EVT_ADDR;
      #1;
      if (rdata != 32'h0) found = 1'b1;
    end
    check_eq("k1_evt_seen", 32'(found), 32'h1);
    check_eq("k1_evt_val", rdata, 32'h02);
    check_eq("k1_irq", 32'(irq), 32'h1);
    clr_read("k1_clr_rdata", 32'h02);
    cycles(20);
    rd_chk("k1_no_second_evt", KSR_EVT_ADDR, 32'h0);
    rd_chk("k1_key_held", KSR_KEY_ADDR, 32'h02);
    rd_chk("sw_after_rst", KSR_SW_ADDR, 32'h0000_000F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
